// File: rtl/ascon_pack.sv
// Shared ASCON types and constants for the permutation datapath.
package ascon_pack;

    // Width of one S-box column (one bit from each of x0..x4).
    localparam int SBOX_W = 5;

    // Permutation state: element 0 is x0 (most significant 64 bits), element 4 is x4.
    typedef logic [0:4][63:0] type_state;

    // Sequencer states of the substitution layer.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sbox_fsm_t;

endpackage

// File: rtl/sbox.sv
// ASCON 5-bit S-box: pure combinational lookup, x_i[4] is the x0 bit of the column.
module sbox
    import ascon_pack::*;
(
    input  logic [SBOX_W-1:0] x_i,
    output logic [SBOX_W-1:0] y_o
);

    // Table lookup of the substituted column
    always_comb begin
        // NOTE: a default assignment ahead of the case keeps this purely combinational even if an item is ever dropped.
        y_o = '0;
        case (x_i)
            5'h00: y_o = 5'h04;
            5'h01: y_o = 5'h0B;
            5'h02: y_o = 5'h1F;
            5'h03: y_o = 5'h14;
            5'h04: y_o = 5'h1A;
            5'h05: y_o = 5'h15;
            5'h06: y_o = 5'h09;
            5'h07: y_o = 5'h02;
            5'h08: y_o = 5'h1B;
            5'h09: y_o = 5'h05;
            5'h0A: y_o = 5'h08;
            5'h0B: y_o = 5'h12;
            5'h0C: y_o = 5'h1D;
            5'h0D: y_o = 5'h03;
            5'h0E: y_o = 5'h06;
            5'h0F: y_o = 5'h1C;
            5'h10: y_o = 5'h1E;
            5'h11: y_o = 5'h13;
            5'h12: y_o = 5'h07;
            5'h13: y_o = 5'h0E;
            5'h14: y_o = 5'h00;
            5'h15: y_o = 5'h0D;
            5'h16: y_o = 5'h11;
            5'h17: y_o = 5'h18;
            5'h18: y_o = 5'h10;
            5'h19: y_o = 5'h0C;
            5'h1A: y_o = 5'h01;
            5'h1B: y_o = 5'h19;
            5'h1C: y_o = 5'h16;
            5'h1D: y_o = 5'h0A;
            5'h1E: y_o = 5'h0F;
            5'h1F: y_o = 5'h17;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/sbox_layer_seq.sv
// Sequential ASCON substitution layer: LANES S-boxes sweep the 64 columns of the
// state over 64/LANES cycles by substituting the low columns and rotating every word.
module sbox_layer_seq
    import ascon_pack::*;
#(
    parameter int LANES = 4
) (
    input  logic      clock_i,
    input  logic      resetb_i,
    input  logic      start_i,
    input  type_state state_i,
    output type_state state_o,
    output logic      busy_o,
    output logic      done_o
);

    localparam int            N    = 64 / LANES;
    localparam int            CW   = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 &&
        LANES != 16 && LANES != 32 && LANES != 64) begin : g_bad_lanes
        $error("sbox_layer_seq: LANES=%0d must be one of 1,2,4,8,16,32,64", LANES);
    end

    sbox_fsm_t         fsm_q, fsm_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    type_state         work_q, work_d;
    type_state         res_q, res_d;
    logic              done_q, done_d;
    logic              last_col;

    type_state         sub_w;   // working register with the low LANES columns substituted
    type_state         rot_w;   // sub_w with every word rotated right by LANES
    logic [SBOX_W-1:0] col_in  [LANES];
    logic [SBOX_W-1:0] col_out [LANES];

    assign last_col = (cnt_q == LAST);

    // One S-box per low column; its output bits are scattered back to x0..x4.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign col_in[l] = {work_q[0][l], work_q[1][l], work_q[2][l], work_q[3][l], work_q[4][l]};

        sbox u_sbox (
            .x_i (col_in[l]),
            .y_o (col_out[l])
        );

        for (genvar w = 0; w < 5; w++) begin : g_bit
            assign sub_w[w][l] = col_out[l][SBOX_W-1-w];
        end
    end

    // Upper columns pass through untouched, then each word rotates right by LANES so
    // the next group of columns lands in the S-box lanes.
    for (genvar w = 0; w < 5; w++) begin : g_word
        if (LANES < 64) begin : g_keep
            assign sub_w[w][63:LANES] = work_q[w][63:LANES];
        end
        for (genvar i = 0; i < 64; i++) begin : g_rot
            assign rot_w[w][i] = sub_w[w][(i + LANES) % 64];
        end
    end

    // FSM state register
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q <= IDLE;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
            fsm_q <= fsm_d;
        end
    end

    // FSM next state: accept a request while idle, leave RUN after the last column group
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (start_i)  fsm_d = RUN;
            RUN:     if (last_col) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Datapath next state: load on acceptance, substitute-and-rotate while running, publish on the last edge
    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        done_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    work_d = state_i;
                    cnt_d  = '0;
                end
            end
            RUN: begin
                work_d = rot_w;
                cnt_d  = cnt_q + 1'b1;
                if (last_col) begin
                    res_d  = rot_w;
                    cnt_d  = '0;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            // NOTE: the wide data registers are reset too, so an aborted run leaves no stale state visible.
            work_q <= '0;
            res_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            work_q <= work_d;
            res_q  <= res_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        busy_o  = (fsm_q == RUN);
        done_o  = done_q;
        state_o = res_q;
    end

endmodule

// File: tb/tb_sbox_layer_seq.sv
// Self-checking bench for sbox_layer_seq at LANES = 1, 4 and 64 against a column-wise p_S model.
module tb_sbox_layer_seq;
    import ascon_pack::*;

    localparam int ND = 3;
    localparam int LN [ND] = '{1, 4, 64};
    localparam logic [4:0] SB [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};

    logic      clk;
    logic      resetb;
    logic      start [ND];
    type_state sin   [ND];
    type_state sout  [ND];
    logic      busy  [ND];
    logic      done  [ND];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        sbox_layer_seq #(.LANES(LN[g])) u_dut (
            .clock_i  (clk),
            .resetb_i (resetb),
            .start_i  (start[g]),
            .state_i  (sin[g]),
            .state_o  (sout[g]),
            .busy_o   (busy[g]),
            .done_o   (done[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference p_S: every column independently through the S-box table.
    function automatic type_state ps(input type_state s);
        type_state  r;
        logic [4:0] v;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            v = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
            v = SB[v];
            for (int w = 0; w < 5; w++) r[w][j] = v[4-w];
        end
        return r;
    endfunction

    function automatic type_state rnd_state();
        type_state s;
        for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
        return s;
    endfunction

    // Start one run on DUT d, wait for done (bounded), check busy, latency and result.
    task automatic run_check(input int d, input type_state s, input type_state exp, input string tag);
        int n;
        bit seen;
        @(negedge clk);
        sin[d]   = s;
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        check({tag, "_busy"}, busy[d], 1);
        n    = 1;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (done[d]) seen = 1'b1;
        end
        check({tag, "_latency"}, n, 1 + 64 / LN[d]);
        check({tag, "_result"}, sout[d], exp);
    endtask

    initial begin
        type_state e, s, a, got;
        int        ndone;

        resetb = 1'b1;
        for (int d = 0; d < ND; d++) begin
            start[d] = 1'b0;
            sin[d]   = '0;
        end
        #2 resetb = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            check("reset_state", sout[d], 0);
            check("reset_busy", busy[d], 0);
            check("reset_done", done[d], 0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) resetb = 1'b1;

        // All-zero state on LANES=4, done must be a single-cycle pulse.
        e = '0;
        e[2] = '1;
        run_check(1, '0, e, "zeros");
        @(posedge clk);
        #1;
        check("zeros_done_one_cycle", done[1], 0);

        // All-ones state.
        e = '1;
        e[1] = '0;
        run_check(1, '1, e, "ones");

        // Single column 37 swept through all 32 values at every lane width.
        for (int d = 0; d < ND; d++) begin
            for (int v = 0; v < 32; v++) begin
                s = '0;
                for (int w = 0; w < 5; w++) s[w][37] = v[4-w];
                run_check(d, s, ps(s), "col37");
            end
        end

        // Back-to-back: run_check starts in the done cycle of the previous run.
        a = rnd_state();
        run_check(1, a, ps(a), "b2b_first");
        a = rnd_state();
        run_check(1, a, ps(a), "b2b_second");

        // start held high during the run and state_i churned: exactly one result of the original state.
        a     = rnd_state();
        ndone = 0;
        got   = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start[1] = (c <= 64 / LN[1] - 1);
            sin[1]   = (c == 0) ? a : rnd_state();
            @(posedge clk);
            #1;
            if (done[1]) begin
                ndone++;
                got = sout[1];
            end
        end
        @(negedge clk) start[1] = 1'b0;
        check("busy_start_one_result", ndone, 1);
        check("busy_start_value", got, ps(a));

        // Reset in cycle 7 of a 16-cycle run.
        @(negedge clk);
        sin[1]   = rnd_state();
        start[1] = 1'b1;
        @(posedge clk);
        #1 start[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midrun_busy_before", busy[1], 1);
        #2 resetb = 1'b0;
        #1;
        check("midrun_reset_busy", busy[1], 0);
        check("midrun_reset_done", done[1], 0);
        check("midrun_reset_state", sout[1], 0);
        @(negedge clk) resetb = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done[1] || busy[1]) ndone++;
        end
        check("midrun_no_resume", ndone, 0);

        // Random regression with 0..3 idle cycles between requests.
        for (int i = 0; i < 1000; i++) begin
            int d;
            int gap;
            d   = i % ND;
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge clk);
            a = rnd_state();
            run_check(d, a, ps(a), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
